// File: rtl/adder_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// adder_defs
// Shared definitions for the adder_accumulator stage: FSM state encodings
// and the default datapath widths used when the block is instantiated
// without overrides.
// ---------------------------------------------------------------------------
package adder_defs;

    // FSM states. Encodings are fixed so the state can be compared
    // against known values through the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Default widths: a 4-bit adder sum plus carry, summed into 8 bits.
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_ACC_W   = 8;
    localparam int DEF_NUM_OPS = 4;

endpackage : adder_defs

// File: rtl/adder_accumulator.sv
// ---------------------------------------------------------------------------
// adder_accumulator
// Sums NUM_OPS successive 4-bit adder results ({C_out, S}, DATA_W+1 bits)
// into an ACC_W-bit accumulator, with a sticky overflow flag and a
// done/ack handshake towards the consumer.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle pulse starting a run (honoured only in IDLE)
//   in_valid  in   S/C_out carry a valid adder result this cycle
//   S         in   adder sum bits [DATA_W-1:0]
//   C_out     in   adder carry out, MSB of the operand
//   ack       in   consumer has taken the result (honoured only in DONE)
//   in_ready  out  operand accepted this cycle (ACCUM)
//   busy      out  high in ACCUM or DONE
//   done      out  result valid, held until ack
//   acc_out   out  accumulated total [ACC_W-1:0]
//   ovf       out  sticky: the accumulator wrapped during this run
//   dbg_state out  current FSM state, for observation only
//
// Handshake: an operand transfers on a rising edge where in_valid and
// in_ready are both high. The result is presented by done=1 and stays
// stable until a rising edge with ack=1 while done=1. in_ready, busy and
// done are decoded from the state register only, so no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module adder_accumulator
    import adder_defs::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int NUM_OPS = DEF_NUM_OPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] S,
    input  logic              C_out,
    input  logic              ack,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_xfer;
    logic             w_last;
    logic [ACC_W:0]   w_sum;

    // One extra bit on the add exposes the carry out of bit ACC_W-1.
    assign w_sum  = {1'b0, r_acc} + (ACC_W + 1)'({C_out, S});
    assign w_xfer = (r_state == ST_ACCUM) && in_valid;
    assign w_last = (r_cnt == LAST_CNT);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_xfer && w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // ack takes priority; a simultaneous start is dropped.
                if (ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, sticky overflow and operand counter.
    // The previous result is kept in IDLE until the next start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= r_ovf | w_sum[ACC_W];
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == ST_ACCUM);
    assign busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule : adder_accumulator

// File: tb/tb_adder_accumulator.sv
// ---------------------------------------------------------------------------
// tb_adder_accumulator
// Directed bench for adder_accumulator. Three instances share one clock:
//   dut   defaults (DATA_W=4, ACC_W=8, NUM_OPS=4)
//   dut6  ACC_W=6 for wrap-around / sticky overflow
//   dut1  NUM_OPS=1
// Inputs are driven and outputs sampled on the falling edge, so every
// value read was settled by the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_adder_accumulator;

    logic clk;
    logic rst_n;

    // default instance
    logic       start, in_valid, c_out, ack;
    logic [3:0] s;
    logic       in_ready, busy, done, ovf;
    logic [7:0] acc_out;
    logic [1:0] dbg_state;

    // ACC_W = 6 instance
    logic       start6, in_valid6, c_out6, ack6;
    logic [3:0] s6;
    logic       in_ready6, busy6, done6, ovf6;
    logic [5:0] acc_out6;
    logic [1:0] dbg_state6;

    // NUM_OPS = 1 instance
    logic       start1, in_valid1, c_out1, ack1;
    logic [3:0] s1;
    logic       in_ready1, busy1, done1, ovf1;
    logic [7:0] acc_out1;
    logic [1:0] dbg_state1;

    int n_checks;
    int n_fail;

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    adder_accumulator #(.DATA_W(4), .ACC_W(8), .NUM_OPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .S(s), .C_out(c_out), .ack(ack), .in_ready(in_ready), .busy(busy),
        .done(done), .acc_out(acc_out), .ovf(ovf), .dbg_state(dbg_state)
    );

    adder_accumulator #(.DATA_W(4), .ACC_W(6), .NUM_OPS(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .in_valid(in_valid6),
        .S(s6), .C_out(c_out6), .ack(ack6), .in_ready(in_ready6), .busy(busy6),
        .done(done6), .acc_out(acc_out6), .ovf(ovf6), .dbg_state(dbg_state6)
    );

    adder_accumulator #(.DATA_W(4), .ACC_W(8), .NUM_OPS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1),
        .S(s1), .C_out(c_out1), .ack(ack1), .in_ready(in_ready1), .busy(busy1),
        .done(done1), .acc_out(acc_out1), .ovf(ovf1), .dbg_state(dbg_state1)
    );

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called at a falling edge, return at the next one)
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic put(input logic c, input logic [3:0] v);
        in_valid = 1'b1;
        c_out    = c;
        s        = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic put6(input logic c, input logic [3:0] v);
        in_valid6 = 1'b1;
        c_out6    = c;
        s6        = v;
        @(negedge clk);
        in_valid6 = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start = 0; in_valid = 0; c_out = 0; s = 0; ack = 0;
        start6 = 0; in_valid6 = 0; c_out6 = 0; s6 = 0; ack6 = 0;
        start1 = 0; in_valid1 = 0; c_out1 = 0; s1 = 0; ack1 = 0;

        // ---- reset then idle, with in_valid noise -----------------------
        in_valid = 1'b1; c_out = 1'b1; s = 4'hF;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        chk("idle_acc",      32'(acc_out),   32'h00);
        chk("idle_ovf",      32'(ovf),       32'h0);
        chk("idle_done",     32'(done),      32'h0);
        chk("idle_in_ready", 32'(in_ready),  32'h0);
        chk("idle_busy",     32'(busy),      32'h0);
        chk("idle_state",    32'(dbg_state), 32'h0);
        in_valid = 1'b0; c_out = 1'b0; s = 4'h0;

        // ---- normal run: 0 + 12 + 14 + 18 = 44 = 0x2C -------------------
        pulse_start();
        chk("run_in_ready", 32'(in_ready), 32'h1);
        chk("run_busy",     32'(busy),     32'h1);
        put(1'b0, 4'd0);
        put(1'b0, 4'd12);
        put(1'b0, 4'd14);
        chk("run_acc3",  32'(acc_out), 32'h1A);
        chk("run_done3", 32'(done),    32'h0);
        put(1'b1, 4'd2);
        chk("run_done",     32'(done),     32'h1);
        chk("run_acc",      32'(acc_out),  32'h2C);
        chk("run_ovf",      32'(ovf),      32'h0);
        chk("run_in_ready_done", 32'(in_ready), 32'h0);
        // in_valid in DONE must not disturb the result
        in_valid = 1'b1; c_out = 1'b1; s = 4'hF;
        cycles(2);
        in_valid = 1'b0;
        chk("done_hold_acc",  32'(acc_out), 32'h2C);
        chk("done_hold_done", 32'(done),    32'h1);
        pulse_ack();
        chk("ack_done", 32'(done),    32'h0);
        chk("ack_busy", 32'(busy),    32'h0);
        chk("ack_acc",  32'(acc_out), 32'h2C);

        // ---- back-to-back start, stalled run ----------------------------
        pulse_start();
        chk("b2b_acc_clear", 32'(acc_out), 32'h00);
        chk("b2b_busy",      32'(busy),    32'h1);
        put(1'b0, 4'd0);
        put(1'b0, 4'd12);
        ack = 1'b1;             // ack outside DONE is ignored
        cycles(3);
        ack = 1'b0;
        chk("stall_in_ready", 32'(in_ready), 32'h1);
        chk("stall_done",     32'(done),     32'h0);
        chk("stall_acc",      32'(acc_out),  32'h0C);
        put(1'b0, 4'd14);
        put(1'b1, 4'd2);
        chk("stall_done_end", 32'(done),    32'h1);
        chk("stall_acc_end",  32'(acc_out), 32'h2C);
        cycles(4);
        chk("stall_done_held", 32'(done), 32'h1);

        // ---- start and ack together in DONE: ack wins -------------------
        start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("sa_state", 32'(dbg_state), 32'h0);
        chk("sa_acc",   32'(acc_out),   32'h2C);
        cycles(1);
        chk("sa_not_queued", 32'(busy),    32'h0);
        chk("sa_acc_kept",   32'(acc_out), 32'h2C);
        pulse_start();
        chk("sa_restart_acc",  32'(acc_out), 32'h00);
        chk("sa_restart_busy", 32'(busy),    32'h1);

        // ---- reset mid-run ----------------------------------------------
        put(1'b1, 4'd15);
        put(1'b1, 4'd15);
        chk("mid_acc", 32'(acc_out), 32'h3E);
        rst_n = 1'b0;
        #1;
        chk("mid_async_acc", 32'(acc_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_state",    32'(dbg_state), 32'h0);
        chk("mid_in_ready", 32'(in_ready),  32'h0);
        chk("mid_acc_rst",  32'(acc_out),   32'h00);
        pulse_start();
        for (int i = 0; i < 4; i++) put(1'b0, 4'd1);
        chk("fresh_acc",  32'(acc_out), 32'h04);
        chk("fresh_done", 32'(done),    32'h1);
        pulse_ack();

        // ---- overflow with ACC_W=6: 31,62,93%64=29 (wrap),60 ------------
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        put6(1'b1, 4'd15);
        put6(1'b1, 4'd15);
        chk("ovf6_acc2", 32'(acc_out6), 32'd62);
        chk("ovf6_ovf2", 32'(ovf6),     32'h0);
        put6(1'b1, 4'd15);
        chk("ovf6_acc3", 32'(acc_out6), 32'd29);
        chk("ovf6_ovf3", 32'(ovf6),     32'h1);
        put6(1'b1, 4'd15);
        chk("ovf6_acc4", 32'(acc_out6), 32'd60);
        chk("ovf6_ovf4", 32'(ovf6),     32'h1);
        chk("ovf6_done", 32'(done6),    32'h1);

        // ---- NUM_OPS=1: done after a single transfer of 23 --------------
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("one_in_ready", 32'(in_ready1), 32'h1);
        in_valid1 = 1'b1; c_out1 = 1'b1; s1 = 4'd7;
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("one_done", 32'(done1),    32'h1);
        chk("one_acc",  32'(acc_out1), 32'h17);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        chk("one_idle", 32'(busy1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_accumulator
